// File: rtl/axi4_bram_slave_pkg.sv
// Shared types and helpers for the AXI4 block-RAM responder.
package axi4_bram_slave_pkg;

    // Burst-level protocol state: one burst (write or read) in flight at a time.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        WRESP = 2'd2,
        RDATA = 2'd3
    } state_e;

    // Number of byte-address bits covered by one data word (log2 of bytes per beat).
    function automatic int calc_bsh(input int d_width);
        return $clog2(d_width / 8);
    endfunction

endpackage

// File: rtl/axi4_bram_slave_ram.sv
// Simple dual-port RAM: one write port, one read port, 1-cycle registered read.
// The read register clears on reset; the array itself keeps its contents.
module axi4_bram_slave_ram #(
    parameter int D_WIDTH    = 16,
    parameter int MEM_AWIDTH = 10
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  we,
    input  logic [MEM_AWIDTH-1:0] waddr,
    input  logic [D_WIDTH-1:0]    wdata,
    input  logic [MEM_AWIDTH-1:0] raddr,
    output logic [D_WIDTH-1:0]    rdata
);

    logic [D_WIDTH-1:0] mem_r [0:(2**MEM_AWIDTH)-1];

    // Write port: store the accepted beat.
    always_ff @(posedge aclk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port: registered output, cleared by reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rdata <= {D_WIDTH{1'b0}};
        end else begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/axi4_bram_slave.sv
// AXI4 INCR-burst responder backed by block RAM. Serves one write (AW/W/B)
// or one read (AR/R) burst at a time; writes win when both requests arrive together.
module axi4_bram_slave
    import axi4_bram_slave_pkg::*;
#(
    parameter int A_WIDTH    = 26,
    parameter int D_WIDTH    = 16,
    parameter int MEM_AWIDTH = 10
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               awvalid,
    output logic               awready,
    input  logic [A_WIDTH-1:0] awaddr,
    input  logic [7:0]         awlen,
    input  logic               wvalid,
    output logic               wready,
    input  logic               wlast,
    input  logic [D_WIDTH-1:0] wdata,
    output logic               bvalid,
    input  logic               bready,
    input  logic               arvalid,
    output logic               arready,
    input  logic [A_WIDTH-1:0] araddr,
    input  logic [7:0]         arlen,
    output logic               rvalid,
    input  logic               rready,
    output logic               rlast,
    output logic [D_WIDTH-1:0] rdata
);

    localparam int BSH = calc_bsh(D_WIDTH);

    state_e                  state_r;
    logic [MEM_AWIDTH-1:0]   idx_r;
    logic [7:0]              len_r;
    logic [7:0]              beat_r;

    logic [A_WIDTH-1:0]      aw_shift_s;
    logic [A_WIDTH-1:0]      ar_shift_s;
    logic [MEM_AWIDTH-1:0]   aw_idx_s;
    logic [MEM_AWIDTH-1:0]   ar_idx_s;
    logic [MEM_AWIDTH-1:0]   idx_next_s;
    logic [MEM_AWIDTH-1:0]   ram_raddr_s;
    logic                    ram_we_s;
    logic                    aw_hs_s;
    logic                    ar_hs_s;
    logic                    w_hs_s;
    logic                    b_hs_s;
    logic                    r_hs_s;
    logic                    unused_s;

    // Byte address -> word index; upper bits beyond the RAM depth are dropped so bursts wrap.
    assign aw_shift_s = awaddr >> BSH;
    assign ar_shift_s = araddr >> BSH;
    assign aw_idx_s   = aw_shift_s[MEM_AWIDTH-1:0];
    assign ar_idx_s   = ar_shift_s[MEM_AWIDTH-1:0];
    assign idx_next_s = idx_r + MEM_AWIDTH'(1);

    // Burst length comes from awlen alone, so wlast is deliberately not consumed.
    assign unused_s = ^{wlast, aw_shift_s, ar_shift_s};

    assign aw_hs_s  = awvalid & awready;
    assign ar_hs_s  = arvalid & arready;
    assign w_hs_s   = wvalid & wready;
    assign b_hs_s   = bvalid & bready;
    assign r_hs_s   = rvalid & rready;
    assign ram_we_s = w_hs_s;

    // Handshake outputs decoded from state; all held low while reset is asserted.
    always_comb begin
        awready = 1'b0;
        arready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        if (!areset) begin
            case (state_r)
                IDLE: begin
                    awready = 1'b1;
                    arready = ~awvalid;
                end
                WDATA: wready = 1'b1;
                WRESP: bvalid = 1'b1;
                RDATA: begin
                    rvalid = 1'b1;
                    rlast  = (beat_r == len_r);
                end
                default: begin
                    awready = 1'b0;
                end
            endcase
        end else begin
            awready = 1'b0;
            arready = 1'b0;
        end
    end

    // RAM read address looks one beat ahead so rdata is ready on the next cycle and holds under stall.
    always_comb begin
        ram_raddr_s = idx_r;
        if (ar_hs_s) begin
            ram_raddr_s = ar_idx_s;
        end else if ((state_r == RDATA) && rready) begin
            ram_raddr_s = idx_next_s;
        end else begin
            ram_raddr_s = idx_r;
        end
    end

    // Burst state machine: latches start index and length, counts beats.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r <= IDLE;
            idx_r   <= {MEM_AWIDTH{1'b0}};
            len_r   <= 8'd0;
            beat_r  <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (aw_hs_s) begin
                        idx_r   <= aw_idx_s;
                        len_r   <= awlen;
                        beat_r  <= 8'd0;
                        state_r <= WDATA;
                    end else if (ar_hs_s) begin
                        idx_r   <= ar_idx_s;
                        len_r   <= arlen;
                        beat_r  <= 8'd0;
                        state_r <= RDATA;
                    end
                end
                WDATA: begin
                    if (w_hs_s) begin
                        idx_r  <= idx_next_s;
                        beat_r <= beat_r + 8'd1;
                        if (beat_r == len_r) begin
                            state_r <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (b_hs_s) begin
                        state_r <= IDLE;
                    end
                end
                RDATA: begin
                    if (r_hs_s) begin
                        idx_r  <= idx_next_s;
                        beat_r <= beat_r + 8'd1;
                        if (rlast) begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    axi4_bram_slave_ram #(
        .D_WIDTH    (D_WIDTH),
        .MEM_AWIDTH (MEM_AWIDTH)
    ) u_ram (
        .aclk   (aclk),
        .areset (areset),
        .we     (ram_we_s),
        .waddr  (idx_r),
        .wdata  (wdata),
        .raddr  (ram_raddr_s),
        .rdata  (rdata)
    );

endmodule

// File: tb/tb_axi4_bram_slave.sv
// Directed bench for axi4_bram_slave with a memory model and an expected-read queue.
module tb_axi4_bram_slave;

    logic        aclk = 1'b0;
    logic        areset;
    logic        awvalid;
    logic        awready;
    logic [25:0] awaddr;
    logic [7:0]  awlen;
    logic        wvalid;
    logic        wready;
    logic        wlast;
    logic [15:0] wdata;
    logic        bvalid;
    logic        bready;
    logic        arvalid;
    logic        arready;
    logic [25:0] araddr;
    logic [7:0]  arlen;
    logic        rvalid;
    logic        rready;
    logic        rlast;
    logic [15:0] rdata;

    int total = 0;
    int bad   = 0;

    logic [15:0] model [0:1023];
    logic [15:0] wbuf  [0:255];
    logic [16:0] exp_q [$];

    always #5 aclk = ~aclk;

    axi4_bram_slave dut (
        .aclk    (aclk),
        .areset  (areset),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .wvalid  (wvalid),
        .wready  (wready),
        .wlast   (wlast),
        .wdata   (wdata),
        .bvalid  (bvalid),
        .bready  (bready),
        .arvalid (arvalid),
        .arready (arready),
        .araddr  (araddr),
        .arlen   (arlen),
        .rvalid  (rvalid),
        .rready  (rready),
        .rlast   (rlast),
        .rdata   (rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int word_idx(input logic [25:0] addr);
        return int'(addr[10:1]);
    endfunction

    // Write burst of len+1 words from wbuf; gap_every>0 inserts wvalid-low cycles.
    task automatic write_burst(input logic [25:0] addr, input int len, input int gap_every, input int bhold);
        int n;
        int beat;
        int cyc;
        @(negedge aclk);
        awvalid = 1'b1; awaddr = addr; awlen = 8'(len);
        #1;
        n = 0;
        while (awready !== 1'b1 && n < 20) begin
            @(negedge aclk); #1; n++;
        end
        check("aw_accept", awready, 1);
        @(negedge aclk);
        awvalid = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat <= len && cyc < 300) begin
            wvalid = (gap_every != 0 && (cyc % gap_every) == 1) ? 1'b0 : 1'b1;
            wdata  = wvalid ? wbuf[beat] : 16'hDEAD;
            wlast  = (beat == len);
            #1;
            if (wvalid && wready === 1'b1) begin
                model[(word_idx(addr) + beat) % 1024] = wbuf[beat];
                beat++;
            end
            @(negedge aclk);
            cyc++;
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("w_beats", beat, len + 1);
        for (int i = 0; i < bhold; i++) begin
            #1;
            check("bvalid_hold", bvalid, 1);
            @(negedge aclk);
        end
        bready = 1'b1;
        #1;
        check("bvalid", bvalid, 1);
        @(negedge aclk);
        bready = 1'b0;
        #1;
        check("bvalid_clear", bvalid, 0);
        check("awready_after_b", awready, 1);
    endtask

    // Read burst; rpat bit (cycle % 32) drives rready.
    task automatic read_burst(input logic [25:0] addr, input int len, input logic [31:0] rpat);
        int n;
        int got;
        int cyc;
        logic        held;
        logic [15:0] prev;
        logic [16:0] e;
        for (int b = 0; b <= len; b++) begin
            exp_q.push_back({1'(b == len), model[(word_idx(addr) + b) % 1024]});
        end
        @(negedge aclk);
        arvalid = 1'b1; araddr = addr; arlen = 8'(len);
        #1;
        n = 0;
        while (arready !== 1'b1 && n < 20) begin
            @(negedge aclk); #1; n++;
        end
        check("ar_accept", arready, 1);
        @(negedge aclk);
        arvalid = 1'b0;
        got  = 0;
        cyc  = 0;
        held = 1'b0;
        prev = 16'h0;
        while (got <= len && cyc < 300) begin
            rready = rpat[cyc % 32];
            #1;
            check("rvalid", rvalid, 1);
            if (held) begin
                check("r_stable", rdata, prev);
            end
            if (rready && rvalid === 1'b1) begin
                e = exp_q.pop_front();
                check("rdata", rdata, e[15:0]);
                check("rlast", rlast, e[16]);
                got++;
            end
            held = ~rready;
            prev = rdata;
            @(negedge aclk);
            cyc++;
        end
        rready = 1'b0;
        check("r_beats", got, len + 1);
        #1;
        check("rvalid_end", rvalid, 0);
        check("arready_end", arready, 1);
    endtask

    initial begin
        logic [16:0] e;
        int          n;
        areset = 1'b1;
        awvalid = 1'b0; awaddr = 26'h0; awlen = 8'h0;
        wvalid = 1'b0; wlast = 1'b0; wdata = 16'h0;
        bready = 1'b0;
        arvalid = 1'b0; araddr = 26'h0; arlen = 8'h0;
        rready = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        check("rst_awready", awready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        areset = 1'b0;
        #1;
        check("idle_awready", awready, 1);
        check("idle_arready", arready, 1);
        check("idle_wready", wready, 0);
        check("idle_bvalid", bvalid, 0);
        check("idle_rvalid", rvalid, 0);

        // 4-beat write then read back
        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
        write_burst(26'h10, 3, 0, 0);
        read_burst(26'h10, 3, 32'hFFFF_FFFF);

        // rready backpressure 1,0,0,1,0,1
        read_burst(26'h10, 2, 32'h0000_0029);

        // wrap at top of memory
        wbuf[0] = 16'hAAAA; wbuf[1] = 16'hBBBB;
        write_burst(26'h7FE, 1, 0, 0);
        read_burst(26'h7FE, 0, 32'hFFFF_FFFF);
        read_burst(26'h0, 0, 32'hFFFF_FFFF);

        // wvalid gaps and bready held low 5 cycles
        for (int i = 0; i < 5; i++) wbuf[i] = 16'h5000 + 16'(i * 16'h0101);
        write_burst(26'h100, 4, 3, 5);
        read_burst(26'h100, 4, 32'hFFFF_FFFF);

        // simultaneous AW and AR: write wins, read accepted after B
        @(negedge aclk);
        awvalid = 1'b1; awaddr = 26'h200; awlen = 8'd0;
        arvalid = 1'b1; araddr = 26'h200; arlen = 8'd0;
        #1;
        check("sim_awready", awready, 1);
        check("sim_arready", arready, 0);
        @(negedge aclk);
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = 16'hC0DE; wlast = 1'b1;
        model[word_idx(26'h200)] = 16'hC0DE;
        exp_q.push_back({1'b1, 16'hC0DE});
        #1;
        check("sim_wready", wready, 1);
        check("sim_arready_w", arready, 0);
        @(negedge aclk);
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        #1;
        check("sim_bvalid", bvalid, 1);
        check("sim_arready_b", arready, 0);
        @(negedge aclk);
        bready = 1'b0;
        #1;
        check("sim_arready_after_b", arready, 1);
        @(negedge aclk);
        arvalid = 1'b0; rready = 1'b1;
        #1;
        check("sim_rvalid", rvalid, 1);
        e = exp_q.pop_front();
        check("sim_rdata", rdata, e[15:0]);
        check("sim_rlast", rlast, e[16]);
        @(negedge aclk);
        rready = 1'b0;
        #1;
        check("sim_rvalid_end", rvalid, 0);

        // reset during beat 2 of an 8-beat read
        for (int i = 0; i < 8; i++) wbuf[i] = 16'h7000 + 16'(i);
        write_burst(26'h300, 7, 0, 0);
        @(negedge aclk);
        arvalid = 1'b1; araddr = 26'h300; arlen = 8'd7;
        #1;
        check("rst_ar_accept", arready, 1);
        @(negedge aclk);
        arvalid = 1'b0; rready = 1'b1;
        #1;
        check("rst_beat1", rdata, 16'h7000);
        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        #1;
        check("rstmid_rvalid", rvalid, 0);
        check("rstmid_rlast", rlast, 0);
        check("rstmid_rdata", rdata, 0);
        check("rstmid_awready", awready, 0);
        check("rstmid_arready", arready, 0);
        check("rstmid_wready", wready, 0);
        check("rstmid_bvalid", bvalid, 0);
        @(negedge aclk);
        areset = 1'b0; rready = 1'b0;
        #1;
        check("rstmid_idle", awready, 1);
        read_burst(26'h300, 7, 32'hFFFF_FFFF);

        n = exp_q.size();
        check("queue_empty", n, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_bram_slave.md
# axi4_bram_slave

AXI4 slave (responder) backed by on-chip block RAM, answering the same AXI4 subset that the UART command bridge drives as a master. It accepts one INCR burst at a time, either a write (AW, W, B) or a read (AR, R), and stores data words in a 2^MEM_AWIDTH-deep RAM. It stands in for the DDR controller so the UART read/write path can be brought up and regressed without external memory.

## Interface
- A_WIDTH, 26: AXI address width in bits; addresses are byte addresses.
- D_WIDTH, 16: data width in bits; must be 8·2^k with k ≥ 0.
- MEM_AWIDTH, 10: RAM word-address width; depth is 2^MEM_AWIDTH words.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- awaddr  in  A_WIDTH  write start byte address.
- awlen  in  8  write beats minus 1.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- wlast  in  1  last write beat (ignored; see Operation).
- wdata  in  D_WIDTH  write data.
- bvalid  out  1  write response valid (response is always OKAY).
- bready  in  1  write response ready.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- araddr  in  A_WIDTH  read start byte address.
- arlen  in  8  read beats minus 1.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- rlast  out  1  last read beat.
- rdata  out  D_WIDTH  read data.

## Operation
- Word index: idx = addr[A_WIDTH-1:BSH] truncated to MEM_AWIDTH bits, where BSH = log2(D_WIDTH/8). Low BSH address bits are ignored. Every beat increments idx by 1, modulo 2^MEM_AWIDTH. Bursts wrap silently at the top of memory.
- State machine: IDLE, WDATA, WRESP, RDATA.
- IDLE: awready = 1 and arready = ~awvalid, so writes win when both are valid.
  - On AW handshake: latch idx and len = awlen, clear the beat counter, go to WDATA.
  - On AR handshake: latch idx and len = arlen, clear the beat counter, go to RDATA.
- WDATA: wready = 1.
  - Each wvalid beat writes mem[idx] = wdata, then increments idx and the beat counter.
  - When the beat counter equals len on an accepted beat, go to WRESP.
  - Burst length is taken from awlen only; wlast is not checked.
- WRESP: bvalid = 1. On bready, go to IDLE.
- RDATA: rvalid = 1, rdata = mem[idx], rlast = (beat counter == len).
  - On rready: increment idx and the beat counter.
  - If rlast was set on that accepted beat, go to IDLE.
- RAM read address (combinational):
  - AR-handshake cycle: start idx.
  - RDATA with rready: idx+1.
  - Otherwise: the current idx.
  - Because of this, rdata holds stable while rready is low.
- Only one burst is in flight at a time, so there is no read/write hazard.
- Reset: state goes to IDLE and all outputs are 0, including rdata. RAM contents are not cleared. A reset in mid-burst abandons the burst; the words already written stay in memory.

## Timing
- All readies and valids are combinational decodes of the state. arready also depends on awvalid. No output depends combinationally on rready, bready or wvalid, except the RAM read address.
- Write: AW handshake at cycle T, wready = 1 from T+1. The beat accepted at cycle C is readable by a burst whose AR handshake is at C+1 or later. Last beat at cycle L gives bvalid = 1 at L+1. A B handshake at cycle H gives awready = 1 at H+1.
- Read: AR handshake at T gives rvalid = 1 at T+1 with the first word. With rready held high, one beat per cycle and no bubbles. The final beat's handshake at cycle E gives rvalid = 0 and arready = 1 at E+1.
- Minimum write turnaround for a 1-beat burst: AW at T, W at T+1, B at T+2, IDLE at T+3.

## Structure
- Package axi4_bram_slave_pkg holds:
  - the state enum (IDLE, WDATA, WRESP, RDATA);
  - a function giving BSH from D_WIDTH.
- Sub-module axi4_bram_slave_ram: simple dual-port RAM with one write port, one read port and a 1-cycle registered read. Its output register resets to 0 synchronously; the memory array is not reset.

## Test plan
- Write then read, 4 beats:
  - stimulus: write awaddr=0x10, awlen=3, data 0x1111/0x2222/0x3333/0x4444, then read araddr=0x10, arlen=3;
  - response: one B response; reads return the same four words in order, with rlast only on beat 4.
- rready backpressure:
  - stimulus: read 3 beats with rready toggling 1,0,0,1,0,1;
  - response: rdata is stable while rready is low; exactly 3 handshakes occur.
- Wrap-around:
  - stimulus: with MEM_AWIDTH=10 and D_WIDTH=16, write awaddr=0x7FE, awlen=1, data 0xAAAA/0xBBBB;
  - response: reading araddr=0x7FE, arlen=0 returns 0xAAAA; reading araddr=0x0, arlen=0 returns 0xBBBB.
- Simultaneous requests:
  - stimulus: awvalid and arvalid rise in the same cycle;
  - response: awready=1 and arready=0 in that cycle; the read is accepted in the cycle after the B handshake.
- Stalls:
  - stimulus: wvalid gaps during a write burst, and bready held low for 5 cycles;
  - response: only beats with wvalid high are written; bvalid stays high until bready.
- Reset mid-read:
  - stimulus: assert areset on beat 2 of an 8-beat read;
  - response: all outputs are 0 the next cycle, and a fresh read returns the previously written data unchanged.
